// File: rtl/sr_to_d_decoder.sv
// Receive-side decoder for an (S, R) command link: rebuilds Q/QN and the
// originating D/En pair, tracks trust in Q, and counts forbidden S=R=1 commands.
module sr_to_d_decoder #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic             s_i,
  input  logic             r_i,
  input  logic             err_clr_i,
  output logic             q_o,
  output logic             qn_o,
  output logic             d_out_o,
  output logic             en_out_o,
  output logic             out_valid_o,
  output logic             known_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned     RC_W     = 4;
  localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RECOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_UNINIT    = 2'd0,
    ST_VALID     = 2'd1,
    ST_FORBIDDEN = 2'd2,
    ST_AMBIG     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              q_q, q_d, qn_q, qn_d;
  logic              d_q, d_d, en_q, en_d;
  logic              ov_q, ov_d, known_q, known_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              illegal;

  assign illegal = in_valid_i & s_i & r_i;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_UNINIT;
      rcnt_q  <= '0;
      q_q     <= 1'b0;
      qn_q    <= 1'b1;
      d_q     <= 1'b0;
      en_q    <= 1'b0;
      ov_q    <= 1'b0;
      known_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      q_q     <= q_d;
      qn_q    <= qn_d;
      d_q     <= d_d;
      en_q    <= en_d;
      ov_q    <= ov_d;
      known_q <= known_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and recovery counter; only a run of idle 00 commands leaves FORBIDDEN without a legal set/reset
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (in_valid_i) begin
      unique case ({s_i, r_i})
        2'b10, 2'b01: begin
          state_d = ST_VALID;
          rcnt_d  = '0;
        end
        2'b11: begin
          state_d = ST_FORBIDDEN;
          rcnt_d  = '0;
        end
        default: begin
          if (state_q == ST_FORBIDDEN) begin
            if (rcnt_q == RC_LAST) begin
              state_d = ST_AMBIG;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + RC_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Next output values
  always_comb begin
    q_d     = q_q;
    qn_d    = qn_q;
    d_d     = d_q;
    en_d    = en_q;
    ov_d    = in_valid_i;
    known_d = (state_d == ST_VALID);
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (in_valid_i) begin
      unique case ({s_i, r_i})
        2'b10: begin
          q_d  = 1'b1;
          qn_d = 1'b0;
          d_d  = 1'b1;
          en_d = 1'b1;
        end
        2'b01: begin
          q_d  = 1'b0;
          qn_d = 1'b1;
          d_d  = 1'b0;
          en_d = 1'b1;
        end
        2'b11: begin
          q_d  = 1'b0;
          qn_d = 1'b0;
          d_d  = 1'b0;
          en_d = 1'b0;
        end
        default: begin
          en_d = 1'b0;
          d_d  = q_q;
          if (state_q == ST_FORBIDDEN && state_d == ST_AMBIG) begin
            q_d  = 1'b0;
            qn_d = 1'b1;
          end
        end
      endcase
    end

    // An illegal command in the same cycle as a clear wins and counts as the first
    if (illegal) begin
      err_d = 1'b1;
      if (err_clr_i)             cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (err_clr_i) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  assign q_o         = q_q;
  assign qn_o        = qn_q;
  assign d_out_o     = d_q;
  assign en_out_o    = en_q;
  assign out_valid_o = ov_q;
  assign known_o     = known_q;
  assign err_o       = err_q;
  assign err_cnt_o   = cnt_q;

endmodule
